sha_mem_responder: RTL and testbench

Word-addressed memory responder serving the memory-master interface of the SHA-256 hashing engine. It answers engine reads with one-cycle registered latency, absorbs engine writes, and captures the eight hash output words into a 256-bit result register with a valid flag. A host-side port preloads message words and reads back results while the engine is idle. Sits beside the engine in the hashing subsystem and the testbench.

---
 rtl/sha_mem_responder_pkg.sv | 13 +
 rtl/sha_mem_responder_if.sv | 28 ++
 rtl/sha_mem_responder_ram.sv | 28 ++
 rtl/sha_mem_responder.sv | 129 ++++++++++++
 tb/tb_sha_mem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_mem_responder_pkg.sv
// Shared types and constants for the SHA-256 engine memory responder.
package sha_mem_pkg;

  typedef enum logic [1:0] {
    ST_HOST = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int          HASH_WORDS_DEF = 8;
  localparam logic [31:0] OOB_RDATA      = 32'h0000_0000;

endpackage

// File: rtl/sha_mem_responder_if.sv
// Engine memory port and host access port of the SHA-256 memory responder.
interface sha_mem_responder_if;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;

  modport master (
    output mem_we, mem_addr, mem_write_data,
    output host_req, host_we, host_addr, host_wdata,
    input  mem_read_data, host_ack, host_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_write_data,
    input  host_req, host_we, host_addr, host_wdata,
    output mem_read_data, host_ack, host_rdata
  );

endinterface

// File: rtl/sha_mem_responder_ram.sv
// Single-port synchronous word array: registered read, write-first on a write.
module sha_mem_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// Memory responder for the SHA-256 engine: host preload/readback while idle,
// engine service while hashing, capture of the hash output window.
// Optional build macro SHA_MEM_RESP_PARITY_EN adds per-word even parity and parity_err.
//   state   | meaning
//   ST_HOST | host port owns the array
//   ST_ARM  | start seen, waiting for engine done to drop
//   ST_RUN  | engine active, engine port owns the array
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int HASH_WORDS = HASH_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    done,
  input  logic [15:0]             out_base,
  sha_mem_responder_if.slave      bus,
  output logic [32*HASH_WORDS-1:0] hash,
  output logic                    hash_valid,
  output logic                    oob_err
`ifdef SHA_MEM_RESP_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
`ifdef SHA_MEM_RESP_PARITY_EN
  localparam int RW = 33;
`else
  localparam int RW = 32;
`endif

  state_e                state;
  logic                  host_ack_q, host_ok_q, eng_ok_q;
  logic [15:0]           base_q;
  logic [HASH_WORDS-1:0] mask;
  logic [31:0]           hash_w [HASH_WORDS];

  logic                  eng_on, host_acc, acc, sel_we, in_rng, win_hit;
  logic [15:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic [IW-1:0]         win_idx;
  logic [RW-1:0]         ram_wdata, ram_rdata;

  always_comb begin
    eng_on    = (state != ST_HOST);
    host_acc  = (state == ST_HOST) && bus.host_req && !host_ack_q;
    acc       = eng_on || host_acc;
    sel_addr  = eng_on ? bus.mem_addr : bus.host_addr;
    sel_wdata = eng_on ? bus.mem_write_data : bus.host_wdata;
    sel_we    = acc && (eng_on ? bus.mem_we : bus.host_we);
    in_rng    = ({1'b0, sel_addr} < 17'(DEPTH));
    // window end is computed at 17 bits so a base near 0xFFFF never wraps to 0
    win_hit   = eng_on && bus.mem_we && (bus.mem_addr >= base_q) &&
                ({1'b0, bus.mem_addr} < ({1'b0, base_q} + 17'(HASH_WORDS)));
    win_idx   = IW'(bus.mem_addr - base_q);
  end

`ifdef SHA_MEM_RESP_PARITY_EN
  assign ram_wdata = {^sel_wdata, sel_wdata};
`else
  assign ram_wdata = sel_wdata;
`endif

  sha_mem_ram #(.DEPTH(DEPTH), .WIDTH(RW)) u_ram (
    .clk   (clk),
    .en    (acc),
    .we    (sel_we && in_rng),
    .addr  (sel_addr[AW-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.mem_read_data = eng_ok_q  ? ram_rdata[31:0] : OOB_RDATA;
  assign bus.host_rdata    = host_ok_q ? ram_rdata[31:0] : OOB_RDATA;
  assign bus.host_ack      = host_ack_q;
  assign hash_valid        = &mask;

  for (genvar i = 0; i < HASH_WORDS; i++) begin : g_hash
    assign hash[32*(HASH_WORDS-i)-1 -: 32] = hash_w[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HOST;
      host_ack_q <= 1'b0;
      host_ok_q  <= 1'b0;
      eng_ok_q   <= 1'b0;
      base_q     <= '0;
      mask       <= '0;
      oob_err    <= 1'b0;
      hash_w     <= '{default: '0};
`ifdef SHA_MEM_RESP_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      host_ack_q <= host_acc;
      host_ok_q  <= host_acc && in_rng;
      eng_ok_q   <= eng_on && in_rng;
      case (state)
        ST_HOST: if (start) begin
          state   <= ST_ARM;
          base_q  <= out_base;
          mask    <= '0;
          oob_err <= 1'b0;
`ifdef SHA_MEM_RESP_PARITY_EN
          parity_err <= 1'b0;
`endif
        end
        ST_ARM:  if (!done) state <= ST_RUN;
        ST_RUN:  if (done)  state <= ST_HOST;
        default: state <= ST_HOST;
      endcase
      if (acc && !in_rng) oob_err <= 1'b1;
      if (win_hit) begin
        hash_w[win_idx] <= bus.mem_write_data;
        mask[win_idx]   <= 1'b1;
      end
`ifdef SHA_MEM_RESP_PARITY_EN
      if ((host_ok_q || eng_ok_q) && (^ram_rdata)) parity_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Randomized self-checking bench for sha_mem_responder against an array/queue model.
module tb_sha_mem_responder;

  localparam int DEPTH = 256;
  localparam int HW    = 8;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic             done     = 1'b1;
  logic [15:0]      out_base = '0;
  logic [32*HW-1:0] hash;
  logic             hash_valid;
  logic             oob_err;
`ifdef SHA_MEM_RESP_PARITY_EN
  logic             parity_err;
`endif

  sha_mem_responder_if bus ();

  sha_mem_responder #(.DEPTH(DEPTH), .HASH_WORDS(HW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .out_base   (out_base),
    .bus        (bus),
    .hash       (hash),
    .hash_valid (hash_valid),
    .oob_err    (oob_err)
`ifdef SHA_MEM_RESP_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model    [DEPTH];
  logic [31:0] exp_hash [HW];
  bit          exp_mask [HW];
  bit          exp_oob  = 1'b0;
  int          cur_base = 0;

  function automatic logic [32*HW-1:0] exp_hash_vec();
    logic [32*HW-1:0] r;
    for (int i = 0; i < HW; i++) r[32*(HW-i)-1 -: 32] = exp_hash[i];
    return r;
  endfunction

  function automatic bit exp_all();
    bit a = 1'b1;
    for (int i = 0; i < HW; i++) a &= exp_mask[i];
    return a;
  endfunction

  task automatic host_op(input bit we, input int addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    if (bus.host_ack) @(negedge clk);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = 16'(addr);
    bus.host_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.host_ack !== 1'b1 && lat < 20);
    rd = bus.host_rdata;
    bus.host_req = 1'b0;
    if (addr < DEPTH) begin
      if (we) model[addr] = wd;
    end else begin
      exp_oob = 1'b1;
    end
  endtask

  task automatic eng_cycle(input bit we, input int addr, input logic [31:0] wd,
                           output logic [31:0] exp_rd);
    @(negedge clk);
    bus.mem_we         = we;
    bus.mem_addr       = 16'(addr);
    bus.mem_write_data = wd;
    exp_rd = 32'h0;
    if (addr < DEPTH) begin
      exp_rd = we ? wd : model[addr];
      if (we) model[addr] = wd;
    end else begin
      exp_oob = 1'b1;
    end
    if (we && addr >= cur_base && addr < cur_base + HW) begin
      exp_hash[addr - cur_base] = wd;
      exp_mask[addr - cur_base] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic begin_run(input int base);
    @(negedge clk);
    start    = 1'b1;
    out_base = 16'(base);
    done     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    done     = 1'b0;
    cur_base = base;
    exp_oob  = 1'b0;
    for (int i = 0; i < HW; i++) exp_mask[i] = 1'b0;
  endtask

  task automatic end_run();
    @(negedge clk);
    done       = 1'b1;
    bus.mem_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL reset_host_ack got %b want 0", bus.host_ack); end
    total++; if (bus.host_rdata !== 32'h0) begin bad++; $display("FAIL reset_host_rdata got %h want 0", bus.host_rdata); end
    total++; if (bus.mem_read_data !== 32'h0) begin bad++; $display("FAIL reset_mem_read_data got %h want 0", bus.mem_read_data); end
    total++; if (hash !== '0) begin bad++; $display("FAIL reset_hash got %h want 0", hash); end
    total++; if (hash_valid !== 1'b0) begin bad++; $display("FAIL reset_hash_valid got %b want 0", hash_valid); end
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL reset_oob_err got %b want 0", oob_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_host_rw();
    logic [31:0] rd;
    int lat;
    for (int a = 0; a < DEPTH; a++) begin
      host_op(1'b1, a, $urandom | 32'h1, rd, lat);
      total++; if (lat != 1) begin bad++; $display("FAIL fill_latency addr %0d got %0d want 1", a, lat); end
    end
    host_op(1'b1, 5, 32'h1234_5678, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL host_write_latency got %0d want 1", lat); end
    host_op(1'b0, 5, 32'h0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL host_read_latency got %0d want 1", lat); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL host_read_addr5 got %h want 12345678", rd); end
    for (int i = 0; i < 20; i++) begin
      int a = $urandom_range(0, DEPTH-1);
      host_op(1'b0, a, 32'h0, rd, lat);
      total++; if (rd !== model[a] || lat != 1) begin bad++; $display("FAIL host_read_rand addr %0d got %h/%0d want %h/1", a, rd, lat, model[a]); end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    @(negedge clk);
    if (bus.host_ack) @(negedge clk);
    a = $urandom_range(0, DEPTH-1);
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 16'(a);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        total++; if (bus.host_ack !== 1'b1 || bus.host_rdata !== model[a]) begin
          bad++; $display("FAIL b2b_ack cycle %0d got %b/%h want 1/%h", i, bus.host_ack, bus.host_rdata, model[a]);
        end
        a = $urandom_range(0, DEPTH-1);
        bus.host_addr = 16'(a);
      end else begin
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL b2b_gap cycle %0d got %b want 0", i, bus.host_ack); end
      end
    end
    bus.host_req = 1'b0;
  endtask

  task automatic test_engine_read();
    logic [31:0] er;
    begin_run(16'h0040);
    eng_cycle(1'b0, 3, 32'h0, er);
    total++; if (bus.mem_read_data !== er) begin bad++; $display("FAIL eng_read_addr3 got %h want %h", bus.mem_read_data, er); end
    for (int i = 0; i < 10; i++) begin
      int a = $urandom_range(0, 19);
      eng_cycle(1'b0, a, 32'h0, er);
      total++; if (bus.mem_read_data !== er) begin bad++; $display("FAIL eng_read_rand addr %0d got %h want %h", a, bus.mem_read_data, er); end
    end
    end_run();
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL eng_read_oob got %b want 0", oob_err); end
  endtask

  task automatic test_hash_capture();
    logic [31:0] er;
    int ord [HW];
    int j, t;
    begin_run(16'h0040);
    total++; if (hash !== exp_hash_vec()) begin bad++; $display("FAIL hash_kept_on_start got %h want %h", hash, exp_hash_vec()); end
    j = $urandom_range(0, HW-1);
    eng_cycle(1'b1, 16'h0040 + j, $urandom, er);
    total++; if (bus.mem_read_data !== er || hash_valid !== 1'b0) begin bad++; $display("FAIL hash_junk got %h/%b want %h/0", bus.mem_read_data, hash_valid, er); end
    for (int i = 0; i < HW; i++) ord[i] = i;
    for (int i = HW-1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < HW; i++) begin
      eng_cycle(1'b1, 16'h0040 + ord[i], 32'hA0 + ord[i], er);
      total++; if (bus.mem_read_data !== er) begin bad++; $display("FAIL hash_write_first got %h want %h", bus.mem_read_data, er); end
      total++; if (hash_valid !== exp_all()) begin bad++; $display("FAIL hash_valid step %0d got %b want %b", i, hash_valid, exp_all()); end
    end
    total++; if (hash !== exp_hash_vec()) begin bad++; $display("FAIL hash_value got %h want %h", hash, exp_hash_vec()); end
    total++; if (hash[255:224] !== 32'hA0 || hash[31:0] !== 32'hA7) begin bad++; $display("FAIL hash_ends got %h/%h want a0/a7", hash[255:224], hash[31:0]); end
    eng_cycle(1'b0, 16'h0042, 32'h0, er);
    total++; if (bus.mem_read_data !== 32'hA2) begin bad++; $display("FAIL hash_mem_readback got %h want a2", bus.mem_read_data); end
    end_run();
  endtask

  task automatic test_host_stall();
    logic [31:0] er;
    begin_run(16'h0300);
    @(negedge clk);
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 16'd5;
    for (int i = 0; i < 5; i++) begin
      eng_cycle(1'b0, $urandom_range(0, DEPTH-1), 32'h0, er);
      total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL stall_ack_run cycle %0d got %b want 0", i, bus.host_ack); end
    end
    end_run();
    total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL stall_ack_enter got %b want 0", bus.host_ack); end
    @(posedge clk); #1;
    total++; if (bus.host_ack !== 1'b1 || bus.host_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL stall_ack_host got %b/%h want 1/12345678", bus.host_ack, bus.host_rdata);
    end
    bus.host_req = 1'b0;
  endtask

  task automatic test_oob();
    logic [31:0] er, rd;
    int lat;
    begin_run(16'h0040);
    eng_cycle(1'b0, 16'h0100, 32'h0, er);
    total++; if (bus.mem_read_data !== 32'h0 || oob_err !== 1'b1) begin bad++; $display("FAIL oob_read got %h/%b want 0/1", bus.mem_read_data, oob_err); end
    eng_cycle(1'b1, 16'h0100, 32'hDEAD_BEEF, er);
    eng_cycle(1'b0, 0, 32'h0, er);
    total++; if (bus.mem_read_data !== er || oob_err !== 1'b1) begin bad++; $display("FAIL oob_write_dropped got %h/%b want %h/1", bus.mem_read_data, oob_err, er); end
    end_run();
    begin_run(16'hFFFC);
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oob_cleared_on_start got %b want 0", oob_err); end
    total++; if (hash !== exp_hash_vec() || hash_valid !== 1'b0) begin bad++; $display("FAIL window_start got %h/%b want %h/0", hash, hash_valid, exp_hash_vec()); end
    for (int a = 16'hFFFC; a <= 16'hFFFF; a++) begin
      eng_cycle(1'b1, a, $urandom, er);
      total++; if (bus.mem_read_data !== er || oob_err !== exp_oob) begin bad++; $display("FAIL window_hi addr %h got %h/%b want %h/%b", a, bus.mem_read_data, oob_err, er, exp_oob); end
    end
    for (int a = 0; a < 4; a++) begin
      eng_cycle(1'b1, a, $urandom, er);
      total++; if (bus.mem_read_data !== er) begin bad++; $display("FAIL window_nowrap addr %0d got %h want %h", a, bus.mem_read_data, er); end
    end
    total++; if (hash !== exp_hash_vec() || hash_valid !== exp_all()) begin bad++; $display("FAIL window_hash got %h/%b want %h/%b", hash, hash_valid, exp_hash_vec(), exp_all()); end
    end_run();
    host_op(1'b0, 16'h1234, 32'h0, rd, lat);
    total++; if (rd !== 32'h0 || lat != 1 || oob_err !== 1'b1) begin bad++; $display("FAIL host_oob_read got %h/%0d/%b want 0/1/1", rd, lat, oob_err); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] er, rd;
    int lat;
    begin_run(16'h0080);
    eng_cycle(1'b0, 16'h01FF, 32'h0, er);
    for (int i = 0; i < 4; i++) eng_cycle(1'b1, 16'h0080 + i, $urandom, er);
    total++; if (hash_valid !== 1'b0 || oob_err !== 1'b1) begin bad++; $display("FAIL pre_reset got %b/%b want 0/1", hash_valid, oob_err); end
    @(negedge clk);
    reset      = 1'b1;
    done       = 1'b1;
    bus.mem_we = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < HW; i++) begin exp_hash[i] = 32'h0; exp_mask[i] = 1'b0; end
    exp_oob = 1'b0;
    total++; if (hash_valid !== 1'b0 || oob_err !== 1'b0 || hash !== exp_hash_vec()) begin
      bad++; $display("FAIL mid_reset got %b/%b/%h want 0/0/0", hash_valid, oob_err, hash);
    end
    @(negedge clk);
    reset = 1'b0;
    host_op(1'b0, 5, 32'h0, rd, lat);
    total++; if (rd !== 32'h1234_5678 || lat != 1) begin bad++; $display("FAIL mid_reset_mem got %h/%0d want 12345678/1", rd, lat); end
  endtask

  task automatic test_random_traffic();
    logic [31:0] rd, er, exp;
    int lat, a;
    bit we;
    for (int i = 0; i < 30; i++) begin
      a   = $urandom_range(0, 299);
      we  = 1'($urandom_range(0, 1));
      exp = (a < DEPTH) ? model[a] : 32'h0;
      host_op(we, a, $urandom, rd, lat);
      total++; if (lat != 1 || (!we && rd !== exp) || oob_err !== exp_oob) begin
        bad++; $display("FAIL rand_host addr %0d we %0d got %h/%0d/%b want %h/1/%b", a, we, rd, lat, oob_err, exp, exp_oob);
      end
    end
    begin_run($urandom_range(0, 260));
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 4) a = cur_base + $urandom_range(0, HW-1);
      else                          a = $urandom_range(0, 299);
      we = 1'($urandom_range(0, 1));
      eng_cycle(we, a, $urandom, er);
      total++; if (bus.mem_read_data !== er || oob_err !== exp_oob || hash_valid !== exp_all()) begin
        bad++; $display("FAIL rand_eng addr %0d we %0d got %h/%b/%b want %h/%b/%b", a, we, bus.mem_read_data, oob_err, hash_valid, er, exp_oob, exp_all());
      end
    end
    total++; if (hash !== exp_hash_vec()) begin bad++; $display("FAIL rand_hash got %h want %h", hash, exp_hash_vec()); end
    end_run();
  endtask

  initial begin
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.host_req       = 1'b0;
    bus.host_we        = 1'b0;
    bus.host_addr      = '0;
    bus.host_wdata     = '0;
    for (int i = 0; i < HW; i++) begin exp_hash[i] = 32'h0; exp_mask[i] = 1'b0; end
    test_reset();
    test_host_rw();
    test_back_to_back();
    test_engine_read();
    test_hash_capture();
    test_host_stall();
    test_oob();
    test_reset_mid_run();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
